frogger_move_encoder: RTL and testbench
=======================================

# frogger_move_encoder

Converts the four debounced direction-switch levels into discrete, handshaked frog-move commands for the game logic. Sits directly downstream of the per-switch debouncers and upstream of the frog position/game FSM. Each press yields one move. A held switch auto-repeats after a delay. A one-entry output slot decouples the encoder from a game FSM that accepts moves only at certain times.

## Interface
- REPEAT_DELAY, default 6_250_000: cycles from a press's first move to the first auto-repeat move (≥2).
- REPEAT_PERIOD, default 3_125_000: cycles between subsequent auto-repeat moves (≥2).
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Up, i_Down, i_Left, i_Right  in  1 each  debounced switch levels, already synchronous to i_Clk, 1 = pressed.
- i_Move_Ready  in  1  consumer accepts the pending move this cycle.
- o_Move_Valid  out  1  a move is pending.
- o_Move_Dir  out  2  pending direction: 00 up, 01 down, 10 left, 11 right. Stable while o_Move_Valid=1 unless overwritten.
- o_Held  out  1  the tracked direction switch is currently held (state HELD).

## Operation
- The 4-bit previous-level register r_Prev samples the inputs every cycle. rise = inputs & ~r_Prev.
- Priority among simultaneous rises: Up > Down > Left > Right. Lower-priority simultaneous rises are discarded.
- FSM states:
  - IDLE: on any rise, go to HELD, latch tracked dir = winning rise, issue a move, clear the repeat counter.
  - HELD, tracked switch low: go to IDLE, no move. A concurrent rise on another switch is evaluated in that same cycle as from IDLE.
  - HELD, rise on a different switch: retarget tracked dir to the winner, issue a move, clear the counter. A rise on the tracked switch itself cannot occur while it is held.
  - HELD, counter reaches REPEAT_DELAY−1 (first repeat) or REPEAT_PERIOD−1 (later repeats): issue a move of tracked dir and clear the counter. A flag r_First selects which limit applies.
- A switch already high when the tracked switch is released issues no move; a new press is required.
- Issuing a move:
  - If the slot is empty, or being accepted this cycle (o_Move_Valid & i_Move_Ready): load dir, valid stays/goes 1.
  - If the slot is full and not accepted: overwrite o_Move_Dir with the new dir (latest wins), valid stays 1.
- Accept with no new move: o_Move_Valid → 0 next cycle.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It saturates only by clearing; no wrap is reachable.
- Reset (any time, mid-press or mid-handshake) drives the following immediately:
  - state IDLE
  - r_Prev = 0000
  - counter = 0
  - r_First = 1
  - o_Move_Valid = 0, o_Move_Dir = 00, o_Held = 0
- After reset release, a switch already held produces a rise on the first clock and therefore one move.

## Timing
- Latency: a rise sampled at edge k gives o_Move_Valid=1 and the new o_Move_Dir after edge k; all outputs are registered.
- First auto-repeat is loaded REPEAT_DELAY cycles after the initial move; subsequent repeats follow every REPEAT_PERIOD cycles.
- Handshake: the transfer occurs on an edge where o_Move_Valid & i_Move_Ready. o_Move_Valid does not depend combinationally on i_Move_Ready.
- o_Held rises with the first move's edge and falls on the edge sampling the release.

## Structure
- Shared package frogger_pkg holds:
  - direction encodings DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11
  - FSM state enum {IDLE, HELD}
- Both are reused by the game FSM. No sub-module; a single flat module.

## Test plan
Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset with i_Up=1, release reset -> exactly one Up move after the first edge, o_Held=1; all outputs 0 while in reset.
- i_Right pulse of 3 cycles, i_Move_Ready=1 -> one move, dir 11, valid for 1 cycle, no repeat.
- i_Left held 20 cycles, ready=1 -> moves at cycles 0, 8, 12, 16; o_Held falls one cycle after release.
- i_Up and i_Down rise together -> one move dir 00; later releasing Up while Down is still held -> no move, state IDLE.
- i_Move_Ready=0; press Down, then Left 3 cycles later -> valid stays 1, dir 10; assert ready -> one transfer with dir 10, valid drops.
- Assert i_Rst for 1 cycle mid-HELD with a pending move -> valid 0 immediately; counter restarts; no repeat move from the prior press.

Source files
------------

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared frog direction encodings and move-encoder state type
package frogger_pkg;

  // Direction codes, also used as the bit index of each switch in the level vector
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

endpackage

// File: rtl/frogger_move_encoder.sv
// rtl/frogger_move_encoder.sv - switch levels to handshaked frog moves with auto-repeat
module frogger_move_encoder
  import frogger_pkg::*;
#(
  parameter int REPEAT_DELAY  = 6_250_000,
  parameter int REPEAT_PERIOD = 3_125_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic       i_Move_Ready,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic       o_Held
);

  localparam int MAX_LIM = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_LIM);
  localparam logic [CW-1:0] LIM_FIRST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] LIM_LATER = CW'(REPEAT_PERIOD - 1);

  // Switch levels indexed by direction code
  logic [3:0]    w_Sw;
  logic [3:0]    r_Prev;
  logic [3:0]    w_Rise;
  logic          w_Any_Rise;
  logic [1:0]    w_Win;

  state_t        r_State, w_State_Next;
  logic [1:0]    r_Dir, w_Dir_Next;
  logic [CW-1:0] r_Cnt, w_Cnt_Next;
  logic          r_First, w_First_Next;
  logic          w_Issue;
  logic [1:0]    w_Issue_Dir;
  logic          w_Repeat_Due;

  logic          r_Valid;
  logic [1:0]    r_Out_Dir;

  assign w_Sw       = {i_Right, i_Left, i_Down, i_Up};
  assign w_Rise     = w_Sw & ~r_Prev;
  assign w_Any_Rise = |w_Rise;
  assign w_Repeat_Due = r_First ? (r_Cnt == LIM_FIRST) : (r_Cnt == LIM_LATER);

  // Pick the highest-priority rising switch; later assignments win, so Up is last
  always_comb begin
    w_Win = DIR_RIGHT;
    if (w_Rise[DIR_LEFT]) w_Win = DIR_LEFT;
    if (w_Rise[DIR_DOWN]) w_Win = DIR_DOWN;
    if (w_Rise[DIR_UP])   w_Win = DIR_UP;
  end

  // Previous-level register for edge detection
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Prev <= 4'b0000;
    else       r_Prev <= w_Sw;
  end

  // Next-state logic: press tracking, retargeting and repeat timing
  always_comb begin
    w_State_Next = r_State;
    w_Dir_Next   = r_Dir;
    w_Cnt_Next   = r_Cnt;
    w_First_Next = r_First;
    w_Issue      = 1'b0;
    w_Issue_Dir  = r_Dir;
    case (r_State)
      IDLE: begin
        if (w_Any_Rise) begin
          w_State_Next = HELD;
          w_Dir_Next   = w_Win;
          w_Issue      = 1'b1;
          w_Issue_Dir  = w_Win;
          w_Cnt_Next   = '0;
          w_First_Next = 1'b1;
        end
      end
      HELD: begin
        // A new press takes over tracking whether or not the old switch was released
        if (w_Any_Rise) begin
          w_Dir_Next   = w_Win;
          w_Issue      = 1'b1;
          w_Issue_Dir  = w_Win;
          w_Cnt_Next   = '0;
          w_First_Next = 1'b1;
        end else if (!w_Sw[r_Dir]) begin
          w_State_Next = IDLE;
          w_Cnt_Next   = '0;
          w_First_Next = 1'b1;
        end else if (w_Repeat_Due) begin
          w_Issue      = 1'b1;
          w_Issue_Dir  = r_Dir;
          w_Cnt_Next   = '0;
          w_First_Next = 1'b0;
        end else begin
          w_Cnt_Next   = r_Cnt + 1'b1;
        end
      end
      default: begin
        w_State_Next = IDLE;
        w_Cnt_Next   = '0;
        w_First_Next = 1'b1;
      end
    endcase
  end

  // FSM state, tracked direction and repeat timer registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Dir   <= DIR_UP;
      r_Cnt   <= '0;
      r_First <= 1'b1;
    end else begin
      r_State <= w_State_Next;
      r_Dir   <= w_Dir_Next;
      r_Cnt   <= w_Cnt_Next;
      r_First <= w_First_Next;
    end
  end

  // One-entry output slot; a new move replaces an unaccepted one
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Valid   <= 1'b0;
      r_Out_Dir <= DIR_UP;
    end else if (w_Issue) begin
      r_Valid   <= 1'b1;
      r_Out_Dir <= w_Issue_Dir;
    end else if (r_Valid && i_Move_Ready) begin
      r_Valid   <= 1'b0;
    end
  end

  assign o_Move_Valid = r_Valid;
  assign o_Move_Dir   = r_Out_Dir;
  assign o_Held       = (r_State == HELD);

endmodule

// File: tb/tb_frogger_move_encoder.sv
// tb/tb_frogger_move_encoder.sv - scoreboard bench for frogger_move_encoder
module tb_frogger_move_encoder;

  localparam int D = 8;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       ready = 1'b0;
  logic       o_Move_Valid;
  logic [1:0] o_Move_Dir;
  logic       o_Held;

  always #5 clk = ~clk;

  frogger_move_encoder #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Up         (up),
    .i_Down       (down),
    .i_Left       (left),
    .i_Right      (right),
    .i_Move_Ready (ready),
    .o_Move_Valid (o_Move_Valid),
    .o_Move_Dir   (o_Move_Dir),
    .o_Held       (o_Held)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int last_dir = -1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: press timestamps in absolute cycles, a pending-slot flag
  logic [3:0] m_prev;
  bit         m_held;
  int         m_track;
  int         next_rep;
  bit         m_valid;
  logic [1:0] m_pdir;
  int         cyc = 0;
  logic [1:0] exp_q[$];

  function void model_clear();
    m_prev   = 4'b0000;
    m_held   = 1'b0;
    m_track  = 0;
    next_rep = 0;
    m_valid  = 1'b0;
    m_pdir   = 2'b00;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] sw, rise;
    bit         issue;
    logic [1:0] idir;
    int         w;
    if (rst) begin
      model_clear();
    end else begin
      sw     = {right, left, down, up};
      rise   = sw & ~m_prev;
      m_prev = sw;
      issue  = 1'b0;
      idir   = 2'b00;
      w      = -1;
      if (m_held && !sw[m_track]) m_held = 1'b0;
      for (int i = 0; i < 4; i++) if (w < 0 && rise[i]) w = i;
      if (w >= 0) begin
        m_held   = 1'b1;
        m_track  = w;
        next_rep = cyc + D;
        issue    = 1'b1;
        idir     = 2'(w);
      end else if (m_held && cyc == next_rep) begin
        issue    = 1'b1;
        idir     = 2'(m_track);
        next_rep = cyc + P;
      end
      if (m_valid && ready) begin
        exp_q.push_back(m_pdir);
        m_valid = 1'b0;
      end
      if (issue) begin
        m_valid = 1'b1;
        m_pdir  = idir;
      end
    end
    cyc++;
  end

  // Monitor: checks outputs each cycle and matches every observed transfer
  bit         prev_x = 1'b0;
  logic [1:0] prev_d = 2'b00;

  always begin
    @(negedge clk);
    #1;
    if (prev_x) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL xfer_unexpected: got dir %0d expected no transfer at %0t", prev_d, $time);
      end else begin
        chk("xfer_dir", int'(prev_d), int'(exp_q.pop_front()));
      end
      n_xfer++;
      last_dir = int'(prev_d);
    end
    chk("valid", int'(o_Move_Valid), int'(m_valid));
    chk("dir",   int'(o_Move_Dir),   int'(m_pdir));
    chk("held",  int'(o_Held),       int'(m_held));
    prev_x = o_Move_Valid && ready;
    prev_d = o_Move_Dir;
  end

  task automatic step(input logic [3:0] sw, input bit rdy, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      up    = sw[0];
      down  = sw[1];
      left  = sw[2];
      right = sw[3];
      ready = rdy;
    end
  endtask

  task automatic set_rst(input bit v);
    @(negedge clk);
    rst = v;
    if (v) model_clear();
  endtask

  task automatic seg_check(input string nm, input int base, input int exp);
    #2;
    chk(nm, n_xfer - base, exp);
  endtask

  int base;
  logic [3:0] rsw;

  initial begin
    model_clear();
    up    = 1'b1;
    ready = 1'b1;

    // Switch held through reset produces exactly one move after release
    base = n_xfer;
    step(4'b0001, 1'b1, 3);
    set_rst(1'b0);
    step(4'b0001, 1'b1, 4);
    step(4'b0000, 1'b1, 4);
    seg_check("seg_reset_up_moves", base, 1);
    chk("seg_reset_up_dir", last_dir, 0);

    // Short Right pulse: one move, no repeat
    base = n_xfer;
    step(4'b1000, 1'b1, 3);
    step(4'b0000, 1'b1, 6);
    seg_check("seg_right_pulse_moves", base, 1);
    chk("seg_right_pulse_dir", last_dir, 3);

    // Left held 20 cycles: initial move plus repeats at 8, 12, 16
    base = n_xfer;
    step(4'b0100, 1'b1, 20);
    step(4'b0000, 1'b1, 6);
    seg_check("seg_left_hold_moves", base, 4);

    // Up and Down together: Up wins; releasing Up with Down held gives nothing
    base = n_xfer;
    step(4'b0011, 1'b1, 3);
    step(4'b0010, 1'b1, 5);
    step(4'b0000, 1'b1, 4);
    seg_check("seg_up_down_moves", base, 1);
    chk("seg_up_down_dir", last_dir, 0);

    // Consumer stalled: Left overwrites the pending Down
    base = n_xfer;
    step(4'b0010, 1'b0, 3);
    step(4'b0110, 1'b0, 2);
    step(4'b0000, 1'b0, 2);
    step(4'b0000, 1'b1, 4);
    seg_check("seg_overwrite_moves", base, 1);
    chk("seg_overwrite_dir", last_dir, 2);

    // Reset mid-press with a pending move: old move dropped, new press after release
    base = n_xfer;
    step(4'b1000, 1'b0, 5);
    set_rst(1'b1);
    set_rst(1'b0);
    step(4'b1000, 1'b0, 5);
    step(4'b0000, 1'b1, 4);
    seg_check("seg_reset_mid_moves", base, 1);

    // Randomized phase
    rsw = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) rsw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        set_rst(1'b1);
        set_rst(1'b0);
      end
      step(rsw, ($urandom_range(0, 3) != 0), 1);
    end
    step(4'b0000, 1'b1, 10);
    #2;
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
